// File: rtl/i2s2_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s2_rx_deserializer
//  Description : Clock generator and I2S receiver for the PMOD-I2S2 ADC path
//                (CS5343). Derives MCLK/SCLK/LRCK from the system clock by a
//                single free-running counter. It deserializes SDIN into
//                DATA_BITS-wide left/right words and presents one l/r pair
//                plus a one-cycle valid strobe per frame.
//  Ports       : clk          - system clock, single clock domain
//                reset        - synchronous, active-high
//                mclk         - ADC master clock  (clk / 2^MCLK_DIV_LOG2)
//                lrck         - word select, 0 = left, 1 = right (mclk/256)
//                sclk         - serial bit clock, 64*Fs (mclk/4)
//                sdin         - ADC serial data, I2S format
//                l_channel    - last complete left sample
//                r_channel    - last complete right sample
//                sample_valid - 1-cycle pulse when l/r_channel update
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s2_rx_deserializer #(
  parameter int MCLK_DIV_LOG2 = 2,
  parameter int DATA_BITS     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mclk,
  output logic                 lrck,
  output logic                 sclk,
  input  logic                 sdin,
  output logic [DATA_BITS-1:0] l_channel,
  output logic [DATA_BITS-1:0] r_channel,
  output logic                 sample_valid
);

  localparam int         c_N        = MCLK_DIV_LOG2;
  localparam int         c_CNT_W    = c_N + 8;
  localparam logic [4:0] c_LAST_BIT = 5'(DATA_BITS);

  // One counter generates every clock and all frame timing, so the pins are
  // plain register bits and the capture point is fixed relative to them.
  logic [c_CNT_W-1:0]   r_div_cnt;
  logic                 r_sdin_q;
  // Only DATA_BITS-1 bits are kept: the newest bit comes straight from
  // r_sdin_q when the word is assembled.
  logic [DATA_BITS-2:0] r_shift;
  logic [DATA_BITS-1:0] r_left_hold;
  logic [DATA_BITS-1:0] r_l_channel;
  logic [DATA_BITS-1:0] r_r_channel;
  logic                 r_sample_valid;

  logic [4:0]           w_bit_idx;
  logic                 w_strobe;
  logic                 w_in_word;
  logic                 w_last_bit;
  logic                 w_lrck;
  logic [DATA_BITS-1:0] w_word;

  assign w_lrck     = r_div_cnt[c_N+7];
  assign w_bit_idx  = r_div_cnt[c_N+6:c_N+2];
  // Last clk of the sclk-high phase: sdin_q holds the bit the ADC launched
  // on the previous sclk fall, well settled.
  assign w_strobe   = &r_div_cnt[c_N+1:0];
  // Bit 0 is the I2S one-bit delay slot; bits past DATA_BITS are padding.
  assign w_in_word  = (w_bit_idx != 5'd0) && (w_bit_idx <= c_LAST_BIT);
  assign w_last_bit = (w_bit_idx == c_LAST_BIT);
  assign w_word     = {r_shift, r_sdin_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      // Counter restarts at a left-frame boundary, so any partial word is
      // simply discarded and the next frame is captured cleanly.
      r_div_cnt      <= '0;
      r_sdin_q       <= 1'b0;
      r_shift        <= '0;
      r_left_hold    <= '0;
      r_l_channel    <= '0;
      r_r_channel    <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_div_cnt      <= r_div_cnt + 1'b1;
      r_sdin_q       <= sdin;
      r_sample_valid <= 1'b0;
      if (w_strobe && w_in_word) begin
        r_shift <= w_word[DATA_BITS-2:0];
        if (w_last_bit) begin
          if (!w_lrck) begin
            r_left_hold <= w_word;
          end else begin
            // Publish the pair together so the consumer never sees a
            // left sample from one frame with a right from another.
            r_l_channel    <= r_left_hold;
            r_r_channel    <= w_word;
            r_sample_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign mclk         = r_div_cnt[c_N-1];
  assign sclk         = r_div_cnt[c_N+1];
  assign lrck         = w_lrck;
  assign l_channel    = r_l_channel;
  assign r_channel    = r_r_channel;
  assign sample_valid = r_sample_valid;

endmodule
`default_nettype wire

// File: tb/tb_i2s2_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s2_rx_deserializer
//  Description : Directed self-checking bench for i2s2_rx_deserializer with
//                an I2S ADC model driven from the DUT's sclk/lrck.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s2_rx_deserializer;

  localparam int c_DB = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            mclk, lrck, sclk;
  logic            sdin = 1'b0;
  logic [c_DB-1:0] l_channel, r_channel;
  logic            sample_valid;

  int checks = 0;
  int errors = 0;

  i2s2_rx_deserializer #(.MCLK_DIV_LOG2(2), .DATA_BITS(c_DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .mclk         (mclk),
    .lrck         (lrck),
    .sclk         (sclk),
    .sdin         (sdin),
    .l_channel    (l_channel),
    .r_channel    (r_channel),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Reference frame counter: restarts on reset, free-runs otherwise.
  logic [9:0] m_cnt = '0;
  always @(posedge clk) begin
    if (reset) m_cnt <= '0;
    else       m_cnt <= m_cnt + 10'd1;
  end

  // ADC model: launches a new bit just after every sclk fall.
  logic [c_DB-1:0] tb_l = '0;
  logic [c_DB-1:0] tb_r = '0;
  logic            tb_fill = 1'b0;
  int              slot = 0;
  logic            bfm_prev = 1'b0;

  always begin
    @(negedge sclk or posedge reset);
    #1;
    if (reset || (lrck !== bfm_prev)) slot = 0;
    else                               slot = slot + 1;
    bfm_prev = reset ? 1'b0 : lrck;
    if (slot >= 1 && slot <= c_DB)
      sdin = lrck ? tb_r[c_DB-slot] : tb_l[c_DB-slot];
    else
      sdin = tb_fill;
  end

  logic [c_DB-1:0] hold_l = '0;
  logic [c_DB-1:0] hold_r = '0;
  logic            prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clk cycle, sampled at the falling edge, with continuous checks.
  task automatic step();
    @(negedge clk);
    if (reset) begin
      chk("rst_mclk",  {31'd0, mclk}, 32'd0);
      chk("rst_sclk",  {31'd0, sclk}, 32'd0);
      chk("rst_lrck",  {31'd0, lrck}, 32'd0);
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_l",     {8'd0, l_channel}, 32'd0);
      chk("rst_r",     {8'd0, r_channel}, 32'd0);
    end else begin
      chk("mclk", {31'd0, mclk}, {31'd0, m_cnt[1]});
      chk("sclk", {31'd0, sclk}, {31'd0, m_cnt[3]});
      chk("lrck", {31'd0, lrck}, {31'd0, m_cnt[9]});
      chk("valid_width", {31'd0, sample_valid && prev_valid}, 32'd0);
      if (sample_valid) begin
        chk("pulse_cnt", {22'd0, m_cnt}, 32'd912);
      end else begin
        chk("hold_l", {8'd0, l_channel}, {8'd0, hold_l});
        chk("hold_r", {8'd0, r_channel}, {8'd0, hold_r});
      end
    end
    prev_valid = sample_valid;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_valid && n < budget);
    chk("pulse_timeout", {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic check_pair(input string tag, input logic [c_DB-1:0] el,
                            input logic [c_DB-1:0] er);
    chk({tag, "_l"}, {8'd0, l_channel}, {8'd0, el});
    chk({tag, "_r"}, {8'd0, r_channel}, {8'd0, er});
    hold_l = el;
    hold_r = er;
  endtask

  initial begin
    int n;

    // 1. Reset, then release; clocks checked against the counter every cycle.
    reset = 1'b1;
    tb_l = 24'h123456; tb_r = 24'hABCDEF; tb_fill = 1'b0;
    repeat (5) step();
    reset = 1'b0;

    // 2. First frame after release, then the following one.
    wait_pulse(2000, n);
    chk("first_latency", n, 32'd912);
    check_pair("t2a", 24'h123456, 24'hABCDEF);
    wait_pulse(2000, n);
    chk("period_a", n, 32'd1024);
    check_pair("t2b", 24'h123456, 24'hABCDEF);

    // 3. Extreme values with all don't-care bits driven high.
    tb_l = 24'h800000; tb_r = 24'h7FFFFF; tb_fill = 1'b1;
    wait_pulse(2000, n);
    chk("period_b", n, 32'd1024);
    check_pair("t3", 24'h800000, 24'h7FFFFF);

    // 4. Reset in the middle of a right half-frame.
    tb_l = 24'h0F0F0F; tb_r = 24'h5A5A5A; tb_fill = 1'b0;
    n = 0;
    while (m_cnt != 10'd600 && n < 2000) begin
      step();
      n++;
    end
    chk("reach_600", {22'd0, m_cnt}, 32'd600);
    reset = 1'b1;
    hold_l = '0;
    hold_r = '0;
    repeat (3) step();
    reset = 1'b0;
    wait_pulse(2000, n);
    chk("post_reset_latency", n, 32'd912);
    check_pair("t4", 24'h0F0F0F, 24'h5A5A5A);

    // 5. sdin stuck high, then stuck low.
    tb_l = 24'hFFFFFF; tb_r = 24'hFFFFFF; tb_fill = 1'b1;
    wait_pulse(2000, n);
    check_pair("t5_ones", 24'hFFFFFF, 24'hFFFFFF);
    tb_l = 24'h000000; tb_r = 24'h000000; tb_fill = 1'b0;
    wait_pulse(2000, n);
    chk("period_c", n, 32'd1024);
    check_pair("t5_zeros", 24'h000000, 24'h000000);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
